// File: rtl/id_stage_pkg.sv
// Shared opcode, result-select and register-address constants plus the
// instruction decoder used by the decode stage.
package id_stage_pkg;

    localparam logic [3:0] MEM_SREG = 4'h1;
    localparam logic [3:0] MEM_DREG = 4'h2;

    localparam logic [7:0] EXE_OR     = 8'b0010_0101;
    localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;

    localparam logic [4:0] NOPRegAddr = 5'b00000;

    typedef struct packed {
        logic [7:0] aluop;
        logic [2:0] alusel;
        logic       reg1_read;
        logic       reg2_read;
        logic       wreg;
        logic       inst_invalid;
    } dec_t;

    // Unknown mem/op combinations decode to a NOP flagged as invalid.
    function automatic dec_t decode(input logic [3:0] mem, input logic [7:0] op);
        dec_t d;
        d.aluop        = EXE_NOP_OP;
        d.alusel       = EXE_RES_NOP;
        d.reg1_read    = 1'b0;
        d.reg2_read    = 1'b0;
        d.wreg         = 1'b0;
        d.inst_invalid = 1'b1;
        if (op == EXE_OR && (mem == MEM_SREG || mem == MEM_DREG)) begin
            d.aluop        = EXE_OR_OP;
            d.alusel       = EXE_RES_LOGIC;
            d.reg1_read    = 1'b1;
            d.reg2_read    = (mem == MEM_DREG);
            d.wreg         = 1'b1;
            d.inst_invalid = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Operand selector for one source register: immediate, zero register,
// EX forward, MEM forward or regfile data, in that priority.
module id_fwd_mux #(
    parameter int REG_W   = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] addr,
    input  logic               read_en,
    input  logic [REG_W-1:0]   imm,
    input  logic [REG_W-1:0]   reg_data,
    input  logic               ex_wreg,
    input  logic [RADDR_W-1:0] ex_wd,
    input  logic [REG_W-1:0]   ex_wdata,
    input  logic               ex_load,
    input  logic               mem_wreg,
    input  logic [RADDR_W-1:0] mem_wd,
    input  logic [REG_W-1:0]   mem_wdata,
    output logic [REG_W-1:0]   operand
);

    always_comb begin
        if (!read_en)
            operand = imm;
        else if (addr == '0)
            operand = '0;
        else if (ex_wreg && ex_wd == addr && !ex_load)
            operand = ex_wdata;
        else if (mem_wreg && mem_wd == addr)
            operand = mem_wdata;
        else
            operand = reg_data;
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: field decode, operand forwarding, load-use hazard detection
// and the ID/EX pipeline register with valid/ready handshake.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int INST_W  = 64,
    parameter int REG_W   = 32,
    parameter int RADDR_W = 5,
    parameter bit FWD_EN  = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        pc_i,
    input  logic [INST_W-1:0]  inst_i,
    output logic               reg1_read_o,
    output logic               reg2_read_o,
    output logic [RADDR_W-1:0] reg1_addr_o,
    output logic [RADDR_W-1:0] reg2_addr_o,
    input  logic [REG_W-1:0]   reg1_data_i,
    input  logic [REG_W-1:0]   reg2_data_i,
    input  logic               ex_wreg_i,
    input  logic [RADDR_W-1:0] ex_wd_i,
    input  logic [REG_W-1:0]   ex_wdata_i,
    input  logic               ex_load_i,
    input  logic               mem_wreg_i,
    input  logic [RADDR_W-1:0] mem_wd_i,
    input  logic [REG_W-1:0]   mem_wdata_i,
    input  logic               flush_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         aluop_o,
    output logic [2:0]         alusel_o,
    output logic [REG_W-1:0]   reg1_o,
    output logic [REG_W-1:0]   reg2_o,
    output logic [RADDR_W-1:0] wd_o,
    output logic               wreg_o,
    output logic [31:0]        pc_o,
    output logic               inst_invalid_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    dec_t               dec;
    logic [RADDR_W-1:0] wd;
    logic [REG_W-1:0]   imm;
    logic [REG_W-1:0]   reg1_sel;
    logic [REG_W-1:0]   reg2_sel;
    logic               ex_fwd;
    logic               mem_fwd;
    logic               hazard;
    logic               adv;

    assign dec = decode(inst_i[63:60], inst_i[59:52]);
    assign wd  = RADDR_W'(inst_i[51:47]);
    assign imm = REG_W'(inst_i[41:10]);

    assign reg1_read_o = in_valid & dec.reg1_read;
    assign reg2_read_o = in_valid & dec.reg2_read;
    assign reg1_addr_o = RADDR_W'(inst_i[46:42]);
    assign reg2_addr_o = RADDR_W'(inst_i[41:37]);

    // With forwarding disabled the muxes only ever see regfile data.
    assign ex_fwd  = ex_wreg_i & FWD_EN;
    assign mem_fwd = mem_wreg_i & FWD_EN;

    id_fwd_mux #(.REG_W(REG_W), .RADDR_W(RADDR_W)) u_fwd1 (
        .addr(reg1_addr_o), .read_en(reg1_read_o), .imm(imm), .reg_data(reg1_data_i),
        .ex_wreg(ex_fwd), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i), .ex_load(ex_load_i),
        .mem_wreg(mem_fwd), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
        .operand(reg1_sel)
    );

    id_fwd_mux #(.REG_W(REG_W), .RADDR_W(RADDR_W)) u_fwd2 (
        .addr(reg2_addr_o), .read_en(reg2_read_o), .imm(imm), .reg_data(reg2_data_i),
        .ex_wreg(ex_fwd), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i), .ex_load(ex_load_i),
        .mem_wreg(mem_fwd), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
        .operand(reg2_sel)
    );

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        logic load_hit;
        logic raw_hit;
        load_hit = 1'b0;
        raw_hit  = 1'b0;
        if (reg1_read_o && reg1_addr_o != '0) begin
            load_hit |= ex_wreg_i && ex_load_i && ex_wd_i == reg1_addr_o;
            raw_hit  |= (ex_wreg_i && ex_wd_i == reg1_addr_o) ||
                        (mem_wreg_i && mem_wd_i == reg1_addr_o);
        end
        if (reg2_read_o && reg2_addr_o != '0) begin
            load_hit |= ex_wreg_i && ex_load_i && ex_wd_i == reg2_addr_o;
            raw_hit  |= (ex_wreg_i && ex_wd_i == reg2_addr_o) ||
                        (mem_wreg_i && mem_wd_i == reg2_addr_o);
        end
        hazard = in_valid && (load_hit || (!FWD_EN && raw_hit));
    end

    assign adv      = out_ready | ~out_valid;
    // A flushed input is consumed and dropped, so it is always accepted.
    assign in_ready = flush_i | (adv & ~hazard);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            wreg_o         <= 1'b0;
            aluop_o        <= EXE_NOP_OP;
            alusel_o       <= EXE_RES_NOP;
            reg1_o         <= '0;
            reg2_o         <= '0;
            wd_o           <= RADDR_W'(NOPRegAddr);
            pc_o           <= '0;
            inst_invalid_o <= 1'b0;
        end else if (flush_i) begin
            out_valid <= 1'b0;
            wreg_o    <= 1'b0;
        end else if (adv) begin
            if (in_valid && !hazard) begin
                out_valid      <= 1'b1;
                wreg_o         <= dec.wreg;
                aluop_o        <= dec.aluop;
                alusel_o       <= dec.alusel;
                reg1_o         <= reg1_sel;
                reg2_o         <= reg2_sel;
                wd_o           <= wd;
                pc_o           <= pc_i;
                inst_invalid_o <= dec.inst_invalid;
            end else begin
                out_valid <= 1'b0;
                wreg_o    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_o <= '0;
        else if (hazard && !flush_i && !(&stall_cnt_o))
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed scoreboard bench for id_stage; a second instance with forwarding
// disabled and a 2-bit counter covers the no-forward hazard and saturation.
module tb_id_stage;
    import id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, flush_i;
    logic [31:0] pc_i;
    logic [63:0] inst_i;
    logic [31:0] reg1_data_i, reg2_data_i, ex_wdata_i, mem_wdata_i;
    logic        ex_wreg_i, ex_load_i, mem_wreg_i;
    logic [4:0]  ex_wd_i, mem_wd_i;

    logic        in_ready, reg1_read_o, reg2_read_o, out_valid, wreg_o, inst_invalid_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o, wd_o;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
    logic [31:0] reg1_o, reg2_o, pc_o;
    logic [15:0] stall_cnt_o;

    logic        in_ready_n, reg1_read_n, reg2_read_n, out_valid_n, wreg_n, inv_n;
    logic [4:0]  reg1_addr_n, reg2_addr_n, wd_n;
    logic [7:0]  aluop_n;
    logic [2:0]  alusel_n;
    logic [31:0] reg1_n, reg2_n, pc_n;
    logic [1:0]  stall_cnt_n;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i),
        .inst_i(inst_i), .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_load_i(ex_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready),
        .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o), .inst_invalid_o(inst_invalid_o),
        .stall_cnt_o(stall_cnt_o)
    );

    id_stage #(.FWD_EN(1'b0), .CNT_W(2)) dut_nofwd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n), .pc_i(pc_i),
        .inst_i(inst_i), .reg1_read_o(reg1_read_n), .reg2_read_o(reg2_read_n),
        .reg1_addr_o(reg1_addr_n), .reg2_addr_o(reg2_addr_n),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_load_i(ex_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i), .out_valid(out_valid_n), .out_ready(out_ready),
        .aluop_o(aluop_n), .alusel_o(alusel_n), .reg1_o(reg1_n), .reg2_o(reg2_n),
        .wd_o(wd_n), .wreg_o(wreg_n), .pc_o(pc_n), .inst_invalid_o(inv_n),
        .stall_cnt_o(stall_cnt_n)
    );

    typedef struct packed {
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic        inv;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wd,
                        input logic wreg, input logic [7:0] aluop, input logic [2:0] alusel,
                        input logic inv, input logic [31:0] pc);
        exp_t e;
        e.reg1 = r1; e.reg2 = r2; e.wd = wd; e.wreg = wreg;
        e.aluop = aluop; e.alusel = alusel; e.inv = inv; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        n_assert++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s.scoreboard: observed empty queue expected an entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".reg1"},   64'(reg1_o),         64'(e.reg1));
            chk({tag, ".reg2"},   64'(reg2_o),         64'(e.reg2));
            chk({tag, ".wd"},     64'(wd_o),           64'(e.wd));
            chk({tag, ".wreg"},   64'(wreg_o),         64'(e.wreg));
            chk({tag, ".aluop"},  64'(aluop_o),        64'(e.aluop));
            chk({tag, ".alusel"}, 64'(alusel_o),       64'(e.alusel));
            chk({tag, ".inv"},    64'(inst_invalid_o), 64'(e.inv));
            chk({tag, ".pc"},     64'(pc_o),           64'(e.pc));
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid),      64'd0);
        chk({tag, ".wreg"},      64'(wreg_o),         64'd0);
        chk({tag, ".aluop"},     64'(aluop_o),        64'(EXE_NOP_OP));
        chk({tag, ".alusel"},    64'(alusel_o),       64'(EXE_RES_NOP));
        chk({tag, ".reg1"},      64'(reg1_o),         64'd0);
        chk({tag, ".reg2"},      64'(reg2_o),         64'd0);
        chk({tag, ".wd"},        64'(wd_o),           64'(NOPRegAddr));
        chk({tag, ".pc"},        64'(pc_o),           64'd0);
        chk({tag, ".inv"},       64'(inst_invalid_o), 64'd0);
        chk({tag, ".stall"},     64'(stall_cnt_o),    64'd0);
        chk({tag, ".stall_n"},   64'(stall_cnt_n),    64'd0);
    endtask

    function automatic logic [63:0] sreg(input logic [4:0] wd, input logic [4:0] rs1,
                                         input logic [31:0] imm);
        logic [63:0] i;
        i = '0;
        i[63:60] = MEM_SREG; i[59:52] = EXE_OR; i[51:47] = wd; i[46:42] = rs1; i[41:10] = imm;
        return i;
    endfunction

    function automatic logic [63:0] dreg(input logic [4:0] wd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
        logic [63:0] i;
        i = '0;
        i[63:60] = MEM_DREG; i[59:52] = EXE_OR; i[51:47] = wd; i[46:42] = rs1; i[41:37] = rs2;
        return i;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush_i = 1'b0;
        pc_i = '0; inst_i = '0; reg1_data_i = '0; reg2_data_i = '0;
        ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0; ex_load_i = 1'b0;
        mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;

        // SREG OR: rs1 from regfile, reg2 operand is the immediate
        pc_i = 32'h100; inst_i = sreg(5'd3, 5'd1, 32'h00F0);
        reg1_data_i = 32'h0F00; reg2_data_i = 32'hDEAD; in_valid = 1'b1;
        #1;
        chk("sreg.reg1_read", 64'(reg1_read_o), 64'd1);
        chk("sreg.reg2_read", 64'(reg2_read_o), 64'd0);
        chk("sreg.reg1_addr", 64'(reg1_addr_o), 64'd1);
        chk("sreg.in_ready",  64'(in_ready),    64'd1);
        chk("sreg.in_ready_n", 64'(in_ready_n), 64'd1);
        push(32'h0F00, 32'h00F0, 5'd3, 1'b1, EXE_OR_OP, EXE_RES_LOGIC, 1'b0, 32'h100);
        tick();
        pop_check("sreg");

        // DREG OR: rs1 forwarded from EX, rs2 forwarded from MEM
        pc_i = 32'h104; inst_i = dreg(5'd7, 5'd2, 5'd4);
        reg1_data_i = 32'h1111; reg2_data_i = 32'h2222;
        ex_wreg_i = 1'b1; ex_wd_i = 5'd2; ex_wdata_i = 32'hAA;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd4; mem_wdata_i = 32'hBB;
        #1;
        chk("fwd.in_ready",   64'(in_ready),   64'd1);
        chk("fwd.in_ready_n", 64'(in_ready_n), 64'd0);
        push(32'hAA, 32'hBB, 5'd7, 1'b1, EXE_OR_OP, EXE_RES_LOGIC, 1'b0, 32'h104);
        tick();
        pop_check("fwd");

        // EX beats MEM on the same register
        pc_i = 32'h108; inst_i = dreg(5'd8, 5'd5, 5'd5);
        ex_wd_i = 5'd5; ex_wdata_i = 32'h11; mem_wd_i = 5'd5; mem_wdata_i = 32'h22;
        push(32'h11, 32'h11, 5'd8, 1'b1, EXE_OR_OP, EXE_RES_LOGIC, 1'b0, 32'h108);
        tick();
        pop_check("prio");

        // r0 reads as zero even with EX/MEM writing r0
        pc_i = 32'h10C; inst_i = dreg(5'd9, 5'd0, 5'd0);
        ex_wd_i = 5'd0; ex_wdata_i = 32'h33; mem_wd_i = 5'd0; mem_wdata_i = 32'h44;
        push(32'h0, 32'h0, 5'd9, 1'b1, EXE_OR_OP, EXE_RES_LOGIC, 1'b0, 32'h10C);
        tick();
        pop_check("r0");

        // Load-use: one bubble, then issue once the load leaves EX
        pc_i = 32'h110; inst_i = dreg(5'd10, 5'd2, 5'd3);
        reg1_data_i = 32'h55; reg2_data_i = 32'h66;
        ex_wreg_i = 1'b1; ex_load_i = 1'b1; ex_wd_i = 5'd2; ex_wdata_i = 32'h99;
        mem_wreg_i = 1'b0;
        #1;
        chk("lu.in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("lu.bubble_valid", 64'(out_valid),   64'd0);
        chk("lu.bubble_wreg",  64'(wreg_o),      64'd0);
        chk("lu.stall_cnt",    64'(stall_cnt_o), 64'd1);
        ex_wreg_i = 1'b0; ex_load_i = 1'b0;
        #1;
        chk("lu.in_ready_after", 64'(in_ready), 64'd1);
        push(32'h55, 32'h66, 5'd10, 1'b1, EXE_OR_OP, EXE_RES_LOGIC, 1'b0, 32'h110);
        tick();
        pop_check("lu");
        chk("lu.stall_cnt_hold", 64'(stall_cnt_o), 64'd1);

        // Back-pressure: payload holds while out_ready is low
        pc_i = 32'h120; inst_i = sreg(5'd12, 5'd6, 32'h1234); reg1_data_i = 32'h77;
        push(32'h77, 32'h1234, 5'd12, 1'b1, EXE_OR_OP, EXE_RES_LOGIC, 1'b0, 32'h120);
        tick();
        pop_check("hold_issue");
        out_ready = 1'b0;
        pc_i = 32'h124; inst_i = sreg(5'd13, 5'd7, 32'h0055); reg1_data_i = 32'h88;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold.in_ready", 64'(in_ready), 64'd0);
            tick();
            chk("hold.valid", 64'(out_valid), 64'd1);
            chk("hold.reg1",  64'(reg1_o),    64'h77);
            chk("hold.reg2",  64'(reg2_o),    64'h1234);
            chk("hold.wd",    64'(wd_o),      64'd12);
            chk("hold.pc",    64'(pc_o),      64'h120);
        end

        // Flush during a load-use hazard: killed, counter untouched
        ex_wreg_i = 1'b1; ex_load_i = 1'b1; ex_wd_i = 5'd7; flush_i = 1'b1;
        #1;
        chk("flush.in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("flush.valid", 64'(out_valid),   64'd0);
        chk("flush.wreg",  64'(wreg_o),      64'd0);
        chk("flush.stall", 64'(stall_cnt_o), 64'd1);
        flush_i = 1'b0; ex_wreg_i = 1'b0; ex_load_i = 1'b0; out_ready = 1'b1;

        // Undecodable instruction issues as an invalid NOP
        pc_i = 32'h130; inst_i = 64'hF000_0000_0000_0000;
        #1;
        chk("inv.reg1_read", 64'(reg1_read_o), 64'd0);
        chk("inv.reg2_read", 64'(reg2_read_o), 64'd0);
        push(32'h0, 32'h0, 5'd0, 1'b0, EXE_NOP_OP, EXE_RES_NOP, 1'b1, 32'h130);
        tick();
        pop_check("inv");

        // Reset in the middle of a stall with the output held
        out_ready = 1'b0;
        pc_i = 32'h140; inst_i = dreg(5'd11, 5'd2, 5'd3);
        ex_wreg_i = 1'b1; ex_load_i = 1'b1; ex_wd_i = 5'd2;
        tick();
        chk("mid.stall", 64'(stall_cnt_o), 64'd2);
        chk("mid.valid", 64'(out_valid),   64'd1);
        rst = 1'b1;
        tick();
        chk_reset("mid_rst");
        rst = 1'b0;

        // No-forward instance stalls on plain EX RAW; its 2-bit counter saturates
        out_ready = 1'b1; ex_load_i = 1'b0; ex_wdata_i = 32'hAB;
        #1;
        chk("sat.in_ready",   64'(in_ready),   64'd1);
        chk("sat.in_ready_n", 64'(in_ready_n), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("sat.stall_n", 64'(stall_cnt_n), 64'd3);
        chk("sat.stall",   64'(stall_cnt_o), 64'd0);
        chk("sat.reg1",    64'(reg1_o),      64'hAB);
        in_valid = 1'b0;

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard.drain: observed %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
